// File: rtl/branch_resolve.sv
// Purpose: resolve one RISC-V conditional branch from ALU NZCV flags; registered taken/target/pc+4 result.
// Latency: 1 cycle from accept to out_valid; one result per cycle when out_ready stays high.
// Backpressure: one-deep output register, in_ready = !out_valid || out_ready; flush kills the held result.
// Optional: define BRANCH_STATS_EN to add the stat_resolved / stat_taken / stat_mispred_hint counters.
module branch_resolve #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_zero,
  input  logic            in_negative,
  input  logic            in_carry,
  input  logic            in_overflow,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic            out_misalign,
  output logic            out_illegal,
  output logic [3:0]      nzcv
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_mispred_hint
`endif
);

  logic            r_out_valid;
  logic            r_taken;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_misalign;
  logic            r_illegal;
  logic [3:0]      r_nzcv;

  logic            w_accept;
  logic            w_taken;
  logic            w_illegal;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_misalign;

  // Ready whenever the output slot is empty or is being drained this cycle.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready && !flush;

  // Address arithmetic wraps at XLEN bits; carry-out is intentionally dropped.
  assign w_target   = in_pc + in_imm;
  assign w_pc_plus4 = in_pc + {{(XLEN-3){1'b0}}, 3'd4};
  assign w_misalign = w_taken && (w_target[1:0] != 2'b00);

  // Branch condition decode; C=1 means A >= B unsigned, so bltu is !C. 010/011 are illegal and never taken.
  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (in_funct3)
      3'b000:  w_taken = in_zero;
      3'b001:  w_taken = !in_zero;
      3'b100:  w_taken = in_negative ^ in_overflow;
      3'b101:  w_taken = !(in_negative ^ in_overflow);
      3'b110:  w_taken = !in_carry;
      3'b111:  w_taken = in_carry;
      default: w_illegal = 1'b1;
    endcase
  end

  // Output valid: flush wins, then a new accept keeps it set, else a take clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Result fields and architectural NZCV load only on accept, so they stay stable under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_taken    <= 1'b0;
      r_target   <= '0;
      r_pc_plus4 <= '0;
      r_misalign <= 1'b0;
      r_illegal  <= 1'b0;
      r_nzcv     <= 4'b0000;
    end else if (w_accept) begin
      r_taken    <= w_taken;
      r_target   <= w_target;
      r_pc_plus4 <= w_pc_plus4;
      r_misalign <= w_misalign;
      r_illegal  <= w_illegal;
      r_nzcv     <= {in_negative, in_zero, in_carry, in_overflow};
    end
  end

  assign out_valid    = r_out_valid;
  assign out_taken    = r_taken;
  assign out_target   = r_target;
  assign out_pc_plus4 = r_pc_plus4;
  assign out_misalign = r_misalign;
  assign out_illegal  = r_illegal;
  assign nzcv         = r_nzcv;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_resolved;
  logic [31:0] r_stat_taken;
  logic [31:0] r_stat_mispred;
  logic        w_mispred;

  // Static backward-taken hint: a negative offset predicts taken.
  assign w_mispred = (w_taken != in_imm[XLEN-1]);

  // Free-running wrapping counters, advanced only by accepts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_resolved <= '0;
      r_stat_taken    <= '0;
      r_stat_mispred  <= '0;
    end else if (w_accept) begin
      r_stat_resolved <= r_stat_resolved + 32'd1;
      if (w_taken)   r_stat_taken   <= r_stat_taken + 32'd1;
      if (w_mispred) r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign stat_resolved     = r_stat_resolved;
  assign stat_taken        = r_stat_taken;
  assign stat_mispred_hint = r_stat_mispred;
`endif

endmodule
